// File: rtl/sram_pkg.sv
// sram_pkg: shared constants and FSM encoding for sram_sp_be
package sram_pkg;
  localparam int RDW_READ_FIRST = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE = 2;
  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;
endpackage

// File: rtl/sram_clear_fsm.sv
// sram_clear_fsm: post-reset clear engine, zeroes words 0..DEPTH-1 then releases busy
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);
  state_t st;
  logic [ADDR_W-1:0] cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= ST_CLEAR;
      cnt <= '0;
      o_busy <= 1'b1;
    end else if (st == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == ADDR_W'(DEPTH - 1)) begin
        st <= ST_IDLE;
        o_busy <= 1'b0;
      end
    end
  end
  assign o_clr_we = st == ST_CLEAR;
  assign o_clr_addr = cnt;
endmodule

// File: rtl/sram_sp_be.sv
// sram_sp_be: single-port byte-enable RAM with clear engine and selectable read-during-write.
// Define SRAM_SP_BE_PARITY_EN for per-lane even parity with error injection.
module sram_sp_be
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH = 64,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ce,
  input  logic                     i_we,
  input  logic [DATA_W/BYTE_W-1:0] i_be,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_data,
`ifdef SRAM_SP_BE_PARITY_EN
  input  logic                     i_perr_inject,
  output logic                     o_perr,
`endif
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_rvalid,
  output logic                     o_busy
);
  localparam int NB = DATA_W / BYTE_W;
  logic busy, clr_we, acc, in_rng, wr, rv, v1;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_w, mrg_w, rd_w, d1;
  sram_clear_fsm #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .o_busy(busy),
    .o_clr_we(clr_we),
    .o_clr_addr(clr_addr)
  );
  assign o_busy = busy;
  always_comb begin
    acc = i_ce && !busy && !i_rst;
    in_rng = {1'b0, i_addr} < (ADDR_W + 1)'(DEPTH);
    wr = acc && i_we;
    rv = acc && !(i_we && RDW_MODE == RDW_NO_CHANGE);
    old_w = in_rng ? mem[i_addr] : '0;
    mrg_w = old_w;
    for (int k = 0; k < NB; k++)
      if (i_be[k]) mrg_w[k*BYTE_W +: BYTE_W] = i_data[k*BYTE_W +: BYTE_W];
    rd_w = (i_we && RDW_MODE == RDW_WRITE_FIRST) ? mrg_w : old_w;
  end
  // clear engine owns the port while busy, so it never collides with traffic
  always_ff @(posedge i_clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    else if (wr && in_rng)
      for (int k = 0; k < NB; k++)
        if (i_be[k]) mem[i_addr][k*BYTE_W +: BYTE_W] <= i_data[k*BYTE_W +: BYTE_W];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rv;
      if (rv) d1 <= rd_w;
    end
  end
`ifdef SRAM_SP_BE_PARITY_EN
  logic [NB-1:0] pmem [DEPTH];
  logic [NB-1:0] old_p, lane_bad, new_p;
  logic err, p1;
  always_comb begin
    old_p = in_rng ? pmem[i_addr] : '0;
    for (int k = 0; k < NB; k++) begin
      lane_bad[k] = (^old_w[k*BYTE_W +: BYTE_W]) != old_p[k];
      new_p[k] = ^i_data[k*BYTE_W +: BYTE_W];
    end
    // freshly written lanes of a merged word carry computed parity, so only old lanes can fail
    err = |(lane_bad & ~((i_we && RDW_MODE == RDW_WRITE_FIRST) ? i_be : '0));
  end
  always_ff @(posedge i_clk) begin
    if (clr_we) pmem[clr_addr] <= '0;
    else if (wr && in_rng)
      for (int k = 0; k < NB; k++)
        if (i_be[k]) pmem[i_addr][k] <= new_p[k] ^ i_perr_inject;
  end
  always_ff @(posedge i_clk) p1 <= i_rst ? 1'b0 : rv && err;
`endif
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] d2;
      logic v2;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          d2 <= d1;
          v2 <= v1;
        end
      end
      assign o_data = d2;
      assign o_rvalid = v2;
`ifdef SRAM_SP_BE_PARITY_EN
      logic p2;
      always_ff @(posedge i_clk) p2 <= i_rst ? 1'b0 : p1;
      assign o_perr = p2;
`endif
    end else begin : g_ocomb
      assign o_data = d1;
      assign o_rvalid = v1;
`ifdef SRAM_SP_BE_PARITY_EN
      assign o_perr = p1;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_sram_sp_be.sv
// tb_sram_sp_be: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE, READ_FIRST+OUT_REG) against a word-level model
module tb_sram_sp_be;
  logic clk = 0, rst = 1, ce = 0, we = 0, inj = 0;
  logic [3:0] be = 0, addr = 0;
  logic [31:0] data = 0;
  logic [31:0] od [4];
  logic ov [4], ob [4], op [4];
  int n_tot = 0, n_bad = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_sp_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .DEPTH(12),
                 .RDW_MODE(g == 3 ? 0 : g), .OUT_REG(g == 3 ? 1 : 0)) u (
      .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_we(we), .i_be(be), .i_addr(addr), .i_data(data),
`ifdef SRAM_SP_BE_PARITY_EN
      .i_perr_inject(inj), .o_perr(op[g]),
`endif
      .o_data(od[g]), .o_rvalid(ov[g]), .o_busy(ob[g]));
  end
`ifndef SRAM_SP_BE_PARITY_EN
  initial for (int i = 0; i < 4; i++) op[i] = 0;
`endif

  // word-level model: memory contents, injected-lane flags, expected outputs per instance
  logic [31:0] m [12];
  logic [3:0] lbad [12];
  logic [31:0] ed [4];
  bit ev [4], ep [4], mbusy, sv, sp;
  logic [31:0] sd;
  int clr_left;
  always @(posedge clk) begin : model
    logic a, inr, pold, pmrg;
    logic [31:0] old, mrg;
    logic [3:0] ob4;
    a = ce && !mbusy && !rst;
    if (rst) begin
      mbusy = 1; clr_left = 12; sd = 0; sv = 0; sp = 0;
      for (int i = 0; i < 12; i++) begin m[i] = 0; lbad[i] = 0; end
      for (int i = 0; i < 4; i++) begin ed[i] = 0; ev[i] = 0; ep[i] = 0; end
    end else begin
      if (clr_left > 0) begin clr_left--; if (clr_left == 0) mbusy = 0; end
      ed[3] = sd; ev[3] = sv; ep[3] = sp;
      if (a) begin
        inr = addr < 12;
        old = inr ? m[addr] : 0;
        ob4 = inr ? lbad[addr] : 0;
        mrg = old;
        for (int k = 0; k < 4; k++) if (be[k]) mrg[k*8 +: 8] = data[k*8 +: 8];
        pold = |ob4;
        pmrg = |(ob4 & ~be);
        ed[0] = old; ev[0] = 1; ep[0] = pold;
        ed[1] = we ? mrg : old; ev[1] = 1; ep[1] = we ? pmrg : pold;
        if (!we) begin ed[2] = old; ev[2] = 1; ep[2] = pold; end
        else begin ev[2] = 0; ep[2] = 0; end
        sd = old; sv = 1; sp = pold;
        if (we && inr) begin
          m[addr] = mrg;
          for (int k = 0; k < 4; k++) if (be[k]) lbad[addr][k] = inj;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin ev[i] = 0; ep[i] = 0; end
        sv = 0; sp = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en)
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy%0d", i), 32'(ob[i]), 32'(mbusy));
      chk($sformatf("rvalid%0d", i), 32'(ov[i]), 32'(ev[i]));
      chk($sformatf("data%0d", i), od[i], ed[i]);
`ifdef SRAM_SP_BE_PARITY_EN
      chk($sformatf("perr%0d", i), 32'(op[i]), 32'(ep[i]));
`endif
    end

  task automatic cyc(input logic c, input logic w, input logic [3:0] b, input logic [3:0] ad,
                     input logic [31:0] d);
    ce = c; we = w; be = b; addr = ad; data = d;
    @(posedge clk); #1;
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask
  task automatic busy_count(input string nm);
    int n = 0;
    while (ob[0] && n < 50) begin cyc(1, 0, 0, 0, 0); n++; end
    chk(nm, n, 12);
  endtask

  initial begin
    idle();
    chk_en = 1;
    idle();
    chk("rst_data", od[0], 0);
    chk("rst_rvalid", 32'(ov[0]), 0);
    chk("rst_busy", 32'(ob[0]), 1);
    rst = 0;
    busy_count("busy_cycles");
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 4'(i), 0);
      chk("clr_read", od[0], 0);
      chk("clr_rvalid", 32'(ov[0]), 1);
    end
    cyc(1, 1, 4'b1111, 3, 32'hAABBCCDD);
    cyc(1, 1, 4'b0101, 3, 32'h11223344);
    cyc(1, 0, 0, 3, 0);
    chk("merge", od[0], 32'hAA22CC44);
    idle();
    chk("merge_oreg", od[3], 32'hAA22CC44);
    cyc(1, 1, 4'b1111, 5, 32'h1);
    idle();
    cyc(1, 1, 4'b1111, 5, 32'h2);
    chk("rdw_rf", od[0], 32'h1);
    chk("rdw_rf_v", 32'(ov[0]), 1);
    chk("rdw_wf", od[1], 32'h2);
    chk("rdw_wf_v", 32'(ov[1]), 1);
    chk("rdw_nc", od[2], 32'hAA22CC44);
    chk("rdw_nc_v", 32'(ov[2]), 0);
    cyc(1, 1, 4'b1111, 7, 32'h77);
    cyc(1, 0, 0, 7, 0);
    chk("raw", od[0], 32'h77);
    for (int i = 0; i < 3; i++) cyc(1, 1, 4'b1111, 4'(i), 32'h100 + i);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    chk("oreg0", od[3], 32'h100);
    cyc(1, 0, 0, 2, 0);
    chk("oreg1", od[3], 32'h101);
    idle();
    chk("oreg2", od[3], 32'h102);
    chk("oreg2_v", 32'(ov[3]), 1);
    idle();
    chk("oreg_idle_v", 32'(ov[3]), 0);
    cyc(1, 1, 4'b1111, 14, 32'hDEADBEEF);
    cyc(1, 0, 0, 14, 0);
    chk("oor_read", od[0], 0);
    chk("oor_rvalid", 32'(ov[0]), 1);
`ifdef SRAM_SP_BE_PARITY_EN
    inj = 1;
    cyc(1, 1, 4'b0010, 2, 32'h0000_5500);
    inj = 0;
    cyc(1, 0, 0, 2, 0);
    chk("perr_inj", 32'(op[0]), 1);
    cyc(1, 0, 0, 1, 0);
    chk("perr_clean", 32'(op[0]), 0);
`endif
    rst = 1; idle(); rst = 0;
    repeat (5) idle();
    rst = 1; idle(); rst = 0;
    busy_count("busy_restart");
    cyc(1, 0, 0, 1, 0);
    rst = 1; idle();
    chk("kill_v", 32'(ov[3]), 0);
    chk("kill_data", od[3], 0);
    rst = 0;
    busy_count("busy_after_kill");
    cyc(1, 0, 0, 3, 0);
    chk("cleared", od[0], 0);
    repeat (3) idle();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_sp_be.md
Name: sram_sp_be

Overview:
- Parametrised single-port synchronous RAM: configurable width/depth, per-byte write enables, selectable read-during-write mode, optional output pipeline register, read-valid strobe.
- Built-in post-reset clear engine zeroes every word before accepting traffic.
- General scratchpad/buffer RAM for datapath blocks needing deterministic contents after reset.

Parameters:
- DATA_W, 32, data word width; must be a multiple of BYTE_W.
- BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes.
- ADDR_W, 6, address width.
- DEPTH, 64, number of words, DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- OUT_REG, 0, 1 adds an output register stage (+1 cycle latency).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_ce  in  1  access request; accepted only when o_busy=0.
- i_we  in  1  1=write, 0=read.
- i_be  in  NB  byte-lane write enables; bit k covers data[k*BYTE_W +: BYTE_W].
- i_addr  in  ADDR_W  word address.
- i_data  in  DATA_W  write data.
- o_data  out  DATA_W  read data.
- o_rvalid  out  1  one-cycle strobe, aligned with o_data update.
- o_busy  out  1  clear engine active; requests ignored.

Behaviour:
- Reset (i_rst=1 at edge): o_data=0, o_rvalid=0, o_busy=1, clear counter=0, FSM -> CLEAR. Reset mid-clear or mid-traffic restarts the clear at address 0; in-flight pipeline data is discarded (o_rvalid=0).
- FSM CLEAR: each cycle writes 0 to mem[cnt], cnt++. After writing DEPTH-1 -> IDLE; o_busy falls on the following edge. Clear takes exactly DEPTH cycles after reset deassertion.
- FSM IDLE: o_busy=0. An access is accepted when i_ce=1.
- Write: lane k of mem[i_addr] is updated iff i_we=1 and i_be[k]=1. If i_be=0, memory is unchanged but the access still counts as a write for read-during-write purposes.
- Read latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), from the accepting edge to o_data/o_rvalid.
- Read (i_we=0): o_data=mem[i_addr], o_rvalid=1.
- Write, READ_FIRST: o_data=old word, o_rvalid=1.
- Write, WRITE_FIRST: o_data=merged word (new lanes where be=1, old elsewhere), o_rvalid=1.
- Write, NO_CHANGE: o_data holds, o_rvalid=0.
- No accepted access: o_data holds its last value, o_rvalid=0.
- Address >= DEPTH: write dropped; read returns 0 with o_rvalid=1.
- Back-to-back accesses are accepted every cycle, with no bubbles. A read of an address written the previous cycle returns the new data.

Optional Feature:
- Macro SRAM_SP_BE_PARITY_EN.
- Defined: one even-parity bit is stored per byte lane, written alongside its lane and cleared to 0 by the clear engine. Added port i_perr_inject (in, 1): when set on a write, the stored parity of the enabled lanes is inverted. Added port o_perr (out, 1): aligned with o_rvalid, 1 if any lane of the returned word fails parity; reset value 0. WRITE_FIRST merged output checks the stored parity of the old lanes and the freshly computed parity of the new lanes.
- Undefined: no parity storage and neither port exists.

Decomposition:
- Package sram_pkg holds RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2, and the FSM state encodings ST_CLEAR, ST_IDLE.
- Sub-module sram_clear_fsm contains the counter, state, and busy logic and drives the clear write port.
- The memory array, byte merge, and output pipeline stay in the top module.

Test Plan (DATA_W=32, ADDR_W=4, DEPTH=12):
- Reset, then read all 12 addresses -> o_busy high for exactly 12 cycles; every read returns 0x00000000 with o_rvalid=1.
- Write 0xAABBCCDD to addr 3 with be=4'b1111, then write 0x11223344 to addr 3 with be=4'b0101 -> subsequent read of addr 3 returns 0xAA22CC44.
- Read-during-write on addr 5 (holding 0x1), writing 0x2: READ_FIRST -> o_data=0x1, rvalid=1; WRITE_FIRST -> 0x2, rvalid=1; NO_CHANGE -> o_data holds, rvalid=0.
- OUT_REG=1, back-to-back reads of addr 0,1,2 -> data appears 2 cycles after each request, on consecutive cycles; write to addr 14 is dropped and a read of addr 14 returns 0.
- Assert i_rst at clear cycle 5 and during a read -> clear restarts from 0 (12 busy cycles); no o_rvalid pulse appears for the killed read.
- With SRAM_SP_BE_PARITY_EN: write addr 2 with i_perr_inject=1, be=4'b0010, then read -> o_perr=1; read addr 1 -> o_perr=0.
